// File: rtl/alu_ctrl.sv
// Multi-cycle datapath controller: a Moore FSM that walks each instruction
// through FETCH / DECODE / EXEC / MEM / WB and produces the datapath
// selects and write enables for the current step.
module alu_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       ZF,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCSrc,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ExtOp,
    output logic [3:0] ALUOp,
    output logic       MemWrite,
    output logic       MDRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemToReg,
    output logic       instr_done,
    output logic [2:0] state
);

    // ALU operation encodings shared with the datapath ALU.
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_OR  = 4'd2;
    localparam logic [3:0] ALU_LUI = 4'd3;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t cur_state;
    state_t next_state;

    logic is_addu, is_subu, is_ori, is_lui, is_lw, is_sw, is_beq, is_nop;

    assign state = cur_state;

    // Instruction classification from the IR fields; unsupported codes are NOPs.
    always_comb begin
        is_addu = (opcode == OP_RTYPE) && (funct == FN_ADDU);
        is_subu = (opcode == OP_RTYPE) && (funct == FN_SUBU);
        is_ori  = (opcode == OP_ORI);
        is_lui  = (opcode == OP_LUI);
        is_lw   = (opcode == OP_LW);
        is_sw   = (opcode == OP_SW);
        is_beq  = (opcode == OP_BEQ);
        is_nop  = !(is_addu || is_subu || is_ori || is_lui || is_lw || is_sw || is_beq);
    end

    // Output decode and next-state selection; write enables are gated off while reset is low.
    always_comb begin
        PCWrite    = 1'b0;
        PCSrc      = 1'b0;
        IRWrite    = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'd0;
        ExtOp      = 1'b0;
        ALUOp      = ALU_ADD;
        MemWrite   = 1'b0;
        MDRWrite   = 1'b0;
        RegWrite   = 1'b0;
        RegDst     = 1'b0;
        MemToReg   = 1'b0;
        instr_done = 1'b0;
        next_state = S_FETCH;

        case (cur_state)
            S_FETCH: begin
                ALUSrcB    = 2'd1;
                PCWrite    = 1'b1;
                IRWrite    = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'd3;
                if (is_nop) begin
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                end else begin
                    next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                if (is_addu) begin
                    next_state = S_WB;
                end else if (is_subu) begin
                    ALUOp      = ALU_SUB;
                    next_state = S_WB;
                end else if (is_ori) begin
                    ALUSrcB    = 2'd2;
                    ALUOp      = ALU_OR;
                    next_state = S_WB;
                end else if (is_lui) begin
                    ALUSrcB    = 2'd2;
                    ALUOp      = ALU_LUI;
                    next_state = S_WB;
                end else if (is_lw || is_sw) begin
                    ALUSrcB    = 2'd2;
                    ExtOp      = 1'b1;
                    next_state = S_MEM;
                end else if (is_beq) begin
                    ALUOp      = ALU_SUB;
                    PCSrc      = 1'b1;
                    PCWrite    = ZF;
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_MEM: begin
                if (is_sw) begin
                    MemWrite   = 1'b1;
                    instr_done = mem_ready;
                    next_state = mem_ready ? S_FETCH : S_MEM;
                end else if (is_lw) begin
                    MDRWrite   = mem_ready;
                    next_state = mem_ready ? S_WB : S_MEM;
                end
            end
            S_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                if (is_addu || is_subu) begin
                    RegDst = 1'b1;
                end else if (is_lw) begin
                    MemToReg = 1'b1;
                end
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase

        if (!reset) begin
            PCWrite    = 1'b0;
            IRWrite    = 1'b0;
            MemWrite   = 1'b0;
            MDRWrite   = 1'b0;
            RegWrite   = 1'b0;
            instr_done = 1'b0;
        end
    end

    // State register with synchronous active-low reset back to FETCH.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cur_state <= S_FETCH;
        end else begin
            cur_state <= next_state;
        end
    end

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed testbench for alu_ctrl: each step pushes the expected output
// vector into a scoreboard queue and pops/compares it mid-cycle.
module tb_alu_ctrl;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_OR  = 4'd2;
    localparam logic [3:0] ALU_LUI = 4'd3;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       ZF;
    logic       mem_ready;
    logic       PCWrite, PCSrc, IRWrite, ALUSrcA, ExtOp;
    logic [1:0] ALUSrcB;
    logic [3:0] ALUOp;
    logic       MemWrite, MDRWrite, RegWrite, RegDst, MemToReg, instr_done;
    logic [2:0] state;

    typedef struct {
        string       tag;
        logic [19:0] vec;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad   = 0;

    alu_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .ZF         (ZF),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .PCSrc      (PCSrc),
        .IRWrite    (IRWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ExtOp      (ExtOp),
        .ALUOp      (ALUOp),
        .MemWrite   (MemWrite),
        .MDRWrite   (MDRWrite),
        .RegWrite   (RegWrite),
        .RegDst     (RegDst),
        .MemToReg   (MemToReg),
        .instr_done (instr_done),
        .state      (state)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Packs outputs in a fixed order: state,PCWrite,PCSrc,IRWrite,ALUSrcA,ALUSrcB,ExtOp,ALUOp,MemWrite,MDRWrite,RegWrite,RegDst,MemToReg,instr_done.
    function automatic logic [19:0] ov(input logic [2:0] st, input logic pcw, input logic pcs,
                                       input logic irw, input logic asa, input logic [1:0] asb,
                                       input logic ext, input logic [3:0] aop, input logic mw,
                                       input logic mdr, input logic rw, input logic rd,
                                       input logic m2r, input logic done);
        return {st, pcw, pcs, irw, asa, asb, ext, aop, mw, mdr, rw, rd, m2r, done};
    endfunction

    function automatic logic [19:0] expFetch();
        return ov(3'd0, 1, 0, 1, 0, 2'd1, 0, ALU_ADD, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic logic [19:0] expDecode(input logic done);
        return ov(3'd1, 0, 0, 0, 0, 2'd3, 0, ALU_ADD, 0, 0, 0, 0, 0, done);
    endfunction

    // Pops the oldest expectation and compares it with the live outputs.
    task automatic checkOutput();
        exp_t        e;
        logic [19:0] obs;
        obs = {state, PCWrite, PCSrc, IRWrite, ALUSrcA, ALUSrcB, ExtOp, ALUOp,
               MemWrite, MDRWrite, RegWrite, RegDst, MemToReg, instr_done};
        total++;
        if (expq.size() == 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_empty: got %h want queued entry", obs);
        end else begin
            e = expq.pop_front();
            assert (obs === e.vec) else begin
                bad++;
                $error("[TB] FAIL %s: got %h want %h", e.tag, obs, e.vec);
            end
        end
    endtask

    // Drives one cycle of inputs, queues its expectation, checks mid-cycle, then advances.
    task automatic applyStimulus(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                                 input logic zf, input logic mr, input string tag,
                                 input logic [19:0] e);
        exp_t item;
        reset     = rst;
        opcode    = op;
        funct     = fn;
        ZF        = zf;
        mem_ready = mr;
        item.tag  = tag;
        item.vec  = e;
        expq.push_back(item);
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    // Directed instruction sequence.
    initial begin
        reset = 1'b0; opcode = 6'd0; funct = 6'd0; ZF = 1'b0; mem_ready = 1'b0;

        // Reset holds FETCH with every write enable forced low.
        applyStimulus(0, 6'h00, 6'h00, 0, 1, "reset0", ov(3'd0, 0, 0, 0, 0, 2'd1, 0, ALU_ADD, 0, 0, 0, 0, 0, 0));
        applyStimulus(0, 6'h3f, 6'h00, 1, 1, "reset1", ov(3'd0, 0, 0, 0, 0, 2'd1, 0, ALU_ADD, 0, 0, 0, 0, 0, 0));

        // addu
        applyStimulus(1, 6'h3f, 6'h00, 0, 0, "addu_fetch", expFetch());
        applyStimulus(1, 6'b000000, 6'b100001, 0, 0, "addu_decode", expDecode(0));
        applyStimulus(1, 6'b000000, 6'b100001, 0, 0, "addu_exec", ov(3'd2, 0, 0, 0, 1, 2'd0, 0, ALU_ADD, 0, 0, 0, 0, 0, 0));
        applyStimulus(1, 6'b000000, 6'b100001, 0, 0, "addu_wb", ov(3'd4, 0, 0, 0, 0, 2'd0, 0, ALU_ADD, 0, 0, 1, 1, 0, 1));

        // beq taken
        applyStimulus(1, 6'b000000, 6'b100001, 0, 0, "beq1_fetch", expFetch());
        applyStimulus(1, 6'b000100, 6'h00, 0, 0, "beq1_decode", expDecode(0));
        applyStimulus(1, 6'b000100, 6'h00, 1, 0, "beq1_exec", ov(3'd2, 1, 1, 0, 1, 2'd0, 0, ALU_SUB, 0, 0, 0, 0, 0, 1));

        // beq not taken
        applyStimulus(1, 6'b000100, 6'h00, 0, 0, "beq0_fetch", expFetch());
        applyStimulus(1, 6'b000100, 6'h00, 0, 0, "beq0_decode", expDecode(0));
        applyStimulus(1, 6'b000100, 6'h00, 0, 0, "beq0_exec", ov(3'd2, 0, 1, 0, 1, 2'd0, 0, ALU_SUB, 0, 0, 0, 0, 0, 1));

        // lw with two stall cycles; mem_ready high outside MEM must be ignored
        applyStimulus(1, 6'b000100, 6'h00, 0, 1, "lw_fetch", expFetch());
        applyStimulus(1, 6'b100011, 6'h00, 0, 1, "lw_decode", expDecode(0));
        applyStimulus(1, 6'b100011, 6'h00, 0, 1, "lw_exec", ov(3'd2, 0, 0, 0, 1, 2'd2, 1, ALU_ADD, 0, 0, 0, 0, 0, 0));
        applyStimulus(1, 6'b100011, 6'h00, 0, 0, "lw_mem_wait0", ov(3'd3, 0, 0, 0, 0, 2'd0, 0, ALU_ADD, 0, 0, 0, 0, 0, 0));
        applyStimulus(1, 6'b100011, 6'h00, 0, 0, "lw_mem_wait1", ov(3'd3, 0, 0, 0, 0, 2'd0, 0, ALU_ADD, 0, 0, 0, 0, 0, 0));
        applyStimulus(1, 6'b100011, 6'h00, 0, 1, "lw_mem_ready", ov(3'd3, 0, 0, 0, 0, 2'd0, 0, ALU_ADD, 0, 1, 0, 0, 0, 0));
        applyStimulus(1, 6'b100011, 6'h00, 0, 1, "lw_wb", ov(3'd4, 0, 0, 0, 0, 2'd0, 0, ALU_ADD, 0, 0, 1, 0, 1, 1));

        // sw with memory ready immediately
        applyStimulus(1, 6'b100011, 6'h00, 0, 0, "sw_fetch", expFetch());
        applyStimulus(1, 6'b101011, 6'h00, 0, 0, "sw_decode", expDecode(0));
        applyStimulus(1, 6'b101011, 6'h00, 0, 0, "sw_exec", ov(3'd2, 0, 0, 0, 1, 2'd2, 1, ALU_ADD, 0, 0, 0, 0, 0, 0));
        applyStimulus(1, 6'b101011, 6'h00, 0, 1, "sw_mem", ov(3'd3, 0, 0, 0, 0, 2'd0, 0, ALU_ADD, 1, 0, 0, 0, 0, 1));

        // ori
        applyStimulus(1, 6'b101011, 6'h00, 0, 0, "ori_fetch", expFetch());
        applyStimulus(1, 6'b001101, 6'h15, 0, 0, "ori_decode", expDecode(0));
        applyStimulus(1, 6'b001101, 6'h15, 0, 0, "ori_exec", ov(3'd2, 0, 0, 0, 1, 2'd2, 0, ALU_OR, 0, 0, 0, 0, 0, 0));
        applyStimulus(1, 6'b001101, 6'h15, 0, 0, "ori_wb", ov(3'd4, 0, 0, 0, 0, 2'd0, 0, ALU_ADD, 0, 0, 1, 0, 0, 1));

        // lui
        applyStimulus(1, 6'b001101, 6'h00, 0, 0, "lui_fetch", expFetch());
        applyStimulus(1, 6'b001111, 6'h00, 0, 0, "lui_decode", expDecode(0));
        applyStimulus(1, 6'b001111, 6'h00, 0, 0, "lui_exec", ov(3'd2, 0, 0, 0, 1, 2'd2, 0, ALU_LUI, 0, 0, 0, 0, 0, 0));
        applyStimulus(1, 6'b001111, 6'h00, 0, 0, "lui_wb", ov(3'd4, 0, 0, 0, 0, 2'd0, 0, ALU_ADD, 0, 0, 1, 0, 0, 1));

        // subu
        applyStimulus(1, 6'b001111, 6'h00, 0, 0, "subu_fetch", expFetch());
        applyStimulus(1, 6'b000000, 6'b100011, 0, 0, "subu_decode", expDecode(0));
        applyStimulus(1, 6'b000000, 6'b100011, 0, 0, "subu_exec", ov(3'd2, 0, 0, 0, 1, 2'd0, 0, ALU_SUB, 0, 0, 0, 0, 0, 0));
        applyStimulus(1, 6'b000000, 6'b100011, 0, 0, "subu_wb", ov(3'd4, 0, 0, 0, 0, 2'd0, 0, ALU_ADD, 0, 0, 1, 1, 0, 1));

        // Unsupported opcode and unsupported R-type funct both act as 2-cycle NOPs
        applyStimulus(1, 6'b000000, 6'b100011, 0, 0, "nop1_fetch", expFetch());
        applyStimulus(1, 6'b111111, 6'h00, 0, 1, "nop1_decode", expDecode(1));
        applyStimulus(1, 6'b111111, 6'h00, 0, 0, "nop2_fetch", expFetch());
        applyStimulus(1, 6'b000000, 6'b100000, 0, 0, "nop2_decode", expDecode(1));

        // sw stalled in MEM, then reset aborts it
        applyStimulus(1, 6'b000000, 6'b100000, 0, 0, "swr_fetch", expFetch());
        applyStimulus(1, 6'b101011, 6'h00, 0, 0, "swr_decode", expDecode(0));
        applyStimulus(1, 6'b101011, 6'h00, 0, 0, "swr_exec", ov(3'd2, 0, 0, 0, 1, 2'd2, 1, ALU_ADD, 0, 0, 0, 0, 0, 0));
        applyStimulus(1, 6'b101011, 6'h00, 0, 0, "swr_mem_wait", ov(3'd3, 0, 0, 0, 0, 2'd0, 0, ALU_ADD, 1, 0, 0, 0, 0, 0));
        applyStimulus(0, 6'b101011, 6'h00, 0, 1, "swr_mem_reset", ov(3'd3, 0, 0, 0, 0, 2'd0, 0, ALU_ADD, 0, 0, 0, 0, 0, 0));
        applyStimulus(1, 6'b101011, 6'h00, 0, 1, "swr_refetch", expFetch());

        // Next instruction after the abort runs normally
        applyStimulus(1, 6'b000000, 6'b100001, 0, 0, "post_decode", expDecode(0));
        applyStimulus(1, 6'b000000, 6'b100001, 0, 0, "post_exec", ov(3'd2, 0, 0, 0, 1, 2'd0, 0, ALU_ADD, 0, 0, 0, 0, 0, 0));
        applyStimulus(1, 6'b000000, 6'b100001, 0, 0, "post_wb", ov(3'd4, 0, 0, 0, 0, 2'd0, 0, ALU_ADD, 0, 0, 1, 1, 0, 1));
        applyStimulus(1, 6'b000000, 6'b100001, 0, 0, "post_fetch", expFetch());

        total++;
        assert (expq.size() == 0) else begin
            bad++;
            $error("[TB] FAIL scoreboard_drain: got %0d want 0", expq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-low; sampled on rising edge of clk.
REQ-003 opcode  input  6  instr[31:26] from the external IR, valid from the cycle after IRWrite.
REQ-004 funct  input  6  instr[5:0] from the external IR.
REQ-005 ZF  input  1  zero flag from the shared ALU.
REQ-006 mem_ready  input  1  data memory completes the current access this cycle.
REQ-007 PCWrite  output  1  PC register load enable.
REQ-008 PCSrc  output  1  PC source: 0 = ALU Result, 1 = ALUOut register.
REQ-009 IRWrite  output  1  IR load enable.
REQ-010 ALUSrcA  output  1  ALU A source: 0 = PC, 1 = register A (rs).
REQ-011 ALUSrcB  output  2  ALU B source: 0 = register B (rt), 1 = constant 4, 2 = extended imm16, 3 = sign-extended imm16 << 2.
REQ-012 ExtOp  output  1  imm16 extension: 1 = sign, 0 = zero.
REQ-013 ALUOp  output  4  the team's alu_add / alu_sub / alu_or / alu_lui encodings only.
REQ-014 MemWrite  output  1  data memory write request.
REQ-015 MDRWrite  output  1  MDR load enable.
REQ-016 RegWrite  output  1  register file write enable.
REQ-017 RegDst  output  1  write address: 0 = rt, 1 = rd.
REQ-018 MemToReg  output  1  write data: 0 = ALUOut, 1 = MDR.
REQ-019 instr_done  output  1  one-cycle pulse in the final cycle of each instruction.
REQ-020 state  output  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.

Function
REQ-021 The block SHALL be a Moore FSM; every output is a function of state, opcode and funct only, except PCWrite in EXEC and the MEM-state handshake outputs.
REQ-022 Supported: addu (op 0, funct 100001), subu (op 0, funct 100011), ori (001101), lui (001111), lw (100011), sw (101011), beq (000100); anything else is a NOP.
REQ-023 FETCH: ALUSrcA=0, ALUSrcB=1, ALUOp=alu_add, PCSrc=0, PCWrite=1, IRWrite=1; next state DECODE.
REQ-024 DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=alu_add (branch target into ALUOut); NOP -> FETCH with instr_done=1, otherwise -> EXEC.
REQ-025 EXEC ALUSrcA=1; addu: B=0, alu_add; subu: B=0, alu_sub; ori: B=2, ExtOp=0, alu_or; lui: B=2, ExtOp=0, alu_lui; lw/sw: B=2, ExtOp=1, alu_add.
REQ-026 EXEC beq: ALUSrcB=0, ALUOp=alu_sub, PCSrc=1, PCWrite=ZF, instr_done=1; next FETCH.
REQ-027 EXEC next state: lw/sw -> MEM; addu/subu/ori/lui -> WB.
REQ-028 MEM sw: MemWrite=1 every cycle in MEM; stays in MEM while mem_ready=0; when mem_ready=1: instr_done=1, next FETCH.
REQ-029 MEM lw: MemWrite=0; MDRWrite=mem_ready; stays while mem_ready=0; when mem_ready=1 -> WB.
REQ-030 WB: RegWrite=1; addu/subu: RegDst=1, MemToReg=0; ori/lui: RegDst=0, MemToReg=0; lw: RegDst=0, MemToReg=1; instr_done=1; next FETCH.
REQ-031 Outputs not listed for a state SHALL be 0 (ALUOp defaults to alu_add).
REQ-032 Latency without MEM stalls: beq 3 cycles, addu/subu/ori/lui/sw 4, lw 5, NOP 2; each mem_ready=0 cycle adds one.
REQ-033 mem_ready is ignored outside MEM.
REQ-034 States 5-7 are unreachable; if entered, next state SHALL be FETCH with all write enables 0.

Reset
REQ-035 While reset=0 at a rising edge, state SHALL become FETCH.
REQ-036 During any cycle with reset=0, PCWrite, IRWrite, MemWrite, MDRWrite, RegWrite and instr_done SHALL be forced to 0, regardless of state.
REQ-037 Reset asserted mid-instruction (any state, including a stalled MEM) SHALL abort it with no further writes; first cycle after release is FETCH.

Verification
REQ-038 Reset then addu (op 0, funct 100001) -> states 0,1,2,4; EXEC ALUOp=alu_add, ALUSrcB=0; WB RegWrite=1, RegDst=1; instr_done in cycle 4 only.
REQ-039 beq with ZF=1, then beq with ZF=0 -> 3 cycles each; EXEC PCWrite=1, PCSrc=1 first, PCWrite=0 second.
REQ-040 lw with mem_ready low 2 cycles after entering MEM -> 7 cycles total; MDRWrite=1 only in the ready cycle; WB MemToReg=1, RegDst=0.
REQ-041 sw with mem_ready=1 immediately -> 4 cycles; MemWrite=1 in MEM only; RegWrite never 1.
REQ-042 opcode 111111 -> FETCH, DECODE, FETCH; instr_done=1 in DECODE; no RegWrite/MemWrite.
REQ-043 reset=0 asserted during a stalled sw MEM cycle -> MemWrite=0 that cycle, state=0 next cycle, next instruction fetched normally.
